// File: rtl/pipelined_approx_adder_pkg.sv
// Shared types for the pipelined exact/approximate adder.
// Mode encoding; reserved behaves as exact.
package approx_adder_pkg;
   typedef enum logic [1:0] {
      MODE_EXACT = 2'b00,
      MODE_LOA   = 2'b01,
      MODE_TRUNC = 2'b10,
      MODE_RSVD  = 2'b11
   } mode_t;
endpackage

// File: rtl/pipelined_approx_adder_if.sv
// Operand/result handshake bundle for pipelined_approx_adder.
interface pipelined_approx_adder_if #(
   parameter int N     = 8,
   parameter int CNT_W = 16
);
   logic                      in_valid;
   logic                      in_ready;
   logic [N-1:0]              a;
   logic [N-1:0]              b;
   logic                      cin;
   approx_adder_pkg::mode_t   mode;
   logic                      out_valid;
   logic                      out_ready;
   logic [N-1:0]              sum;
   logic                      cout;
   logic                      err_flag;
   logic [N:0]                err_dist;
   logic [CNT_W-1:0]          err_count;
   logic                      clr_stats;

   modport master (
      output in_valid, a, b, cin, mode, out_ready, clr_stats,
      input  in_ready, out_valid, sum, cout, err_flag, err_dist, err_count
   );
   modport slave (
      input  in_valid, a, b, cin, mode, out_ready, clr_stats,
      output in_ready, out_valid, sum, cout, err_flag, err_dist, err_count
   );
endinterface

// File: rtl/pipelined_approx_adder_slice.sv
// One W-bit slice: exact and approximate ripple chains side by side.
// IDX locates the slice within the word so bits below K can be approximated.
module approx_adder_slice
   import approx_adder_pkg::*;
#(
   parameter int W   = 4,
   parameter int IDX = 0,
   parameter int K   = 3
) (
   input  mode_t        mode,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin_x,
   input  logic         cin_a,
   output logic [W-1:0] sum_x,
   output logic [W-1:0] sum_a,
   output logic         cout_x,
   output logic         cout_a
);
   logic       approx, loa;
   logic [W:0] cx, ca;

   assign approx = (mode == MODE_LOA) || (mode == MODE_TRUNC);
   assign loa    = (mode == MODE_LOA);

   always_comb begin
      cx    = '0;
      ca    = '0;
      sum_x = '0;
      sum_a = '0;
      cx[0] = cin_x;
      ca[0] = cin_a;
      for (int i = 0; i < W; i++) begin
         sum_x[i]  = a[i] ^ b[i] ^ cx[i];
         cx[i+1]   = (a[i] & b[i]) | (cx[i] & (a[i] ^ b[i]));
         // Approximate LSBs never propagate a carry, except LOA's generate into bit K.
         if (approx && (IDX*W + i < K)) begin
            sum_a[i] = loa & (a[i] | b[i]);
            ca[i+1]  = (IDX*W + i == K-1) & loa & a[i] & b[i];
         end else begin
            sum_a[i] = a[i] ^ b[i] ^ ca[i];
            ca[i+1]  = (a[i] & b[i]) | (ca[i] & (a[i] ^ b[i]));
         end
      end
   end

   assign cout_x = cx[W];
   assign cout_a = ca[W];
endmodule

// File: rtl/pipelined_approx_adder.sv
// STAGES-deep sliced adder with exact shadow sum and error statistics.
// The last stage register is the output register; the whole pipe stalls together.
module pipelined_approx_adder
   import approx_adder_pkg::*;
#(
   parameter int N      = 8,
   parameter int STAGES = 2,
   parameter int K      = 3,
   parameter int CNT_W  = 16
) (
   input logic                   clk,
   input logic                   rst,
   pipelined_approx_adder_if.slave bus
);
   localparam int W    = N / STAGES;
   localparam int LAST = STAGES - 1;

   logic                         advance;
   logic [STAGES-1:0]            v_in, vld_pipe;
   logic [STAGES-1:0][1:0]       m_in, mode_q;
   logic [STAGES-1:0][N-1:0]     a_in, b_in, a_q, b_q;
   logic [STAGES-1:0][N-1:0]     sx_d, sa_d, sx_q, sa_q;
   logic [STAGES-1:0]            cx_in, ca_in, cx_d, ca_d, cx_q, ca_q;
   logic [N:0]                   ex_full, ap_full, dist_d;

   assign advance      = !vld_pipe[LAST] || bus.out_ready;
   assign bus.in_ready = advance;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      if (s == 0) begin : g_head
         assign v_in[s]  = bus.in_valid;
         assign m_in[s]  = bus.mode;
         assign a_in[s]  = bus.a;
         assign b_in[s]  = bus.b;
         assign cx_in[s] = bus.cin;
         // cin is dropped by approximate modes unless nothing is approximated.
         assign ca_in[s] = (K > 0 && (bus.mode == MODE_LOA || bus.mode == MODE_TRUNC))
                           ? 1'b0 : bus.cin;
      end else begin : g_body
         assign v_in[s]  = vld_pipe[s-1];
         assign m_in[s]  = mode_q[s-1];
         assign a_in[s]  = a_q[s-1];
         assign b_in[s]  = b_q[s-1];
         assign cx_in[s] = cx_q[s-1];
         assign ca_in[s] = ca_q[s-1];
         assign sx_d[s][s*W-1:0] = sx_q[s-1][s*W-1:0];
         assign sa_d[s][s*W-1:0] = sa_q[s-1][s*W-1:0];
      end
      if (s < LAST) begin : g_upper
         assign sx_d[s][N-1:(s+1)*W] = '0;
         assign sa_d[s][N-1:(s+1)*W] = '0;
      end

      approx_adder_slice #(.W(W), .IDX(s), .K(K)) u_slice (
         .mode   (mode_t'(m_in[s])),
         .a      (a_in[s][s*W +: W]),
         .b      (b_in[s][s*W +: W]),
         .cin_x  (cx_in[s]),
         .cin_a  (ca_in[s]),
         .sum_x  (sx_d[s][s*W +: W]),
         .sum_a  (sa_d[s][s*W +: W]),
         .cout_x (cx_d[s]),
         .cout_a (ca_d[s])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
         mode_q   <= '0;
         a_q      <= '0;
         b_q      <= '0;
         sx_q     <= '0;
         sa_q     <= '0;
         cx_q     <= '0;
         ca_q     <= '0;
      end else if (advance) begin
         vld_pipe <= v_in;
         mode_q   <= m_in;
         a_q      <= a_in;
         b_q      <= b_in;
         sx_q     <= sx_d;
         sa_q     <= sa_d;
         cx_q     <= cx_d;
         ca_q     <= ca_d;
      end
   end

   assign ex_full = {cx_d[LAST], sx_d[LAST]};
   assign ap_full = {ca_d[LAST], sa_d[LAST]};
   assign dist_d  = (ex_full >= ap_full) ? (ex_full - ap_full) : (ap_full - ex_full);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.err_flag <= 1'b0;
         bus.err_dist <= '0;
      end else if (advance) begin
         bus.err_flag <= (ex_full != ap_full);
         bus.err_dist <= dist_d;
      end
   end

   // Clear beats a same-cycle increment; the count sticks at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         bus.err_count <= '0;
      else if (bus.clr_stats)
         bus.err_count <= '0;
      else if (vld_pipe[LAST] && bus.out_ready && bus.err_flag && (bus.err_count != '1))
         bus.err_count <= bus.err_count + 1'b1;
   end

   assign bus.out_valid = vld_pipe[LAST];
   assign bus.sum       = sa_q[LAST];
   assign bus.cout      = ca_q[LAST];
endmodule

// File: tb/tb_pipelined_approx_adder.sv
// Directed test of pipelined_approx_adder at N=8, STAGES=2, K=3.
module tb_pipelined_approx_adder;
   import approx_adder_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [7:0] r_sum;
   logic       r_cout, r_flag;
   logic [8:0] r_dist;
   int         r_lat;

   always #5 clk = ~clk;

   pipelined_approx_adder_if #(.N(8), .CNT_W(16)) bus ();

   pipelined_approx_adder #(.N(8), .STAGES(2), .K(3), .CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Single transaction on an empty pipe; result is consumed on presentation.
   task automatic run_vec(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                          input mode_t vm);
      bus.a = va; bus.b = vb; bus.cin = vc; bus.mode = vm;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      r_lat = 0;
      while (!bus.out_valid && r_lat < 10) begin
         @(posedge clk); #1;
         r_lat++;
      end
      r_sum = bus.sum; r_cout = bus.cout; r_flag = bus.err_flag; r_dist = bus.err_dist;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      bus.in_valid = 0; bus.out_ready = 1; bus.clr_stats = 0;
      bus.a = 0; bus.b = 0; bus.cin = 0; bus.mode = MODE_EXACT;
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      n_checks++; if (bus.sum !== 8'h00 || bus.cout !== 1'b0) begin n_fail++; $display("FAIL reset_sum got=%h/%b exp=00/0", bus.sum, bus.cout); end
      n_checks++; if (bus.err_count !== 16'h0 || bus.err_flag !== 1'b0 || bus.err_dist !== 9'h0) begin n_fail++; $display("FAIL reset_err got=%h/%b/%h exp=0", bus.err_count, bus.err_flag, bus.err_dist); end
      rst = 0;
      #1;
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_exact();
      run_vec(8'h03, 8'h57, 1'b1, MODE_EXACT);
      n_checks++; if (r_lat !== 1) begin n_fail++; $display("FAIL exact_latency got=%0d exp=1 edge after accept", r_lat); end
      n_checks++; if (r_sum !== 8'h5B || r_cout !== 1'b0) begin n_fail++; $display("FAIL exact_sum got=%h/%b exp=5b/0", r_sum, r_cout); end
      n_checks++; if (r_flag !== 1'b0 || r_dist !== 9'd0) begin n_fail++; $display("FAIL exact_err got=%b/%0d exp=0/0", r_flag, r_dist); end
      run_vec(8'h03, 8'h57, 1'b1, MODE_RSVD);
      n_checks++; if (r_sum !== 8'h5B || r_flag !== 1'b0) begin n_fail++; $display("FAIL rsvd_sum got=%h/%b exp=5b/0", r_sum, r_flag); end
      n_checks++; if (bus.err_count !== 16'd0) begin n_fail++; $display("FAIL exact_count got=%0d exp=0", bus.err_count); end
   endtask

   task automatic test_loa();
      run_vec(8'h2B, 8'h31, 1'b1, MODE_LOA);
      n_checks++; if (r_sum !== 8'h5B || r_cout !== 1'b0) begin n_fail++; $display("FAIL loa_sum got=%h/%b exp=5b/0", r_sum, r_cout); end
      n_checks++; if (r_flag !== 1'b1 || r_dist !== 9'd2) begin n_fail++; $display("FAIL loa_err got=%b/%0d exp=1/2", r_flag, r_dist); end
      n_checks++; if (bus.err_count !== 16'd1) begin n_fail++; $display("FAIL loa_count got=%0d exp=1", bus.err_count); end
   endtask

   task automatic test_trunc();
      run_vec(8'h80, 8'h41, 1'b1, MODE_TRUNC);
      n_checks++; if (r_sum !== 8'hC0 || r_cout !== 1'b0) begin n_fail++; $display("FAIL trunc_sum got=%h/%b exp=c0/0", r_sum, r_cout); end
      n_checks++; if (r_flag !== 1'b1 || r_dist !== 9'd2) begin n_fail++; $display("FAIL trunc_err got=%b/%0d exp=1/2", r_flag, r_dist); end
      n_checks++; if (bus.err_count !== 16'd2) begin n_fail++; $display("FAIL trunc_count got=%0d exp=2", bus.err_count); end
   endtask

   task automatic test_wrap();
      run_vec(8'hFF, 8'h01, 1'b0, MODE_EXACT);
      n_checks++; if (r_sum !== 8'h00 || r_cout !== 1'b1 || r_dist !== 9'd0) begin n_fail++; $display("FAIL wrap_exact got=%h/%b/%0d exp=00/1/0", r_sum, r_cout, r_dist); end
      run_vec(8'hFF, 8'hFF, 1'b0, MODE_LOA);
      n_checks++; if (r_sum !== 8'hFF || r_cout !== 1'b1) begin n_fail++; $display("FAIL wrap_loa_sum got=%h/%b exp=ff/1", r_sum, r_cout); end
      n_checks++; if (r_flag !== 1'b1 || r_dist !== 9'd1) begin n_fail++; $display("FAIL wrap_loa_err got=%b/%0d exp=1/1", r_flag, r_dist); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] got [4];
      logic [7:0] held;
      int sent, rcvd, cyc;
      logic acc, xfer;
      sent = 0; rcvd = 0; held = 0;
      bus.out_ready = 0; bus.cin = 0; bus.mode = MODE_EXACT; bus.b = 8'h10;
      for (cyc = 0; cyc < 30 && rcvd < 4; cyc++) begin
         bus.out_ready = (cyc >= 6);
         bus.in_valid  = (sent < 4);
         bus.a         = 8'(sent * 17);
         if (cyc == 3) held = bus.sum;
         if (cyc == 5) begin
            n_checks++; if (sent !== 2 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall got sent=%0d in_ready=%b exp=2/0", sent, bus.in_ready); end
            n_checks++; if (bus.sum !== held || bus.sum !== 8'h10 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold got=%h/%b exp=10/1", bus.sum, bus.out_valid); end
         end
         #1;
         acc  = bus.in_valid && bus.in_ready;
         xfer = bus.out_valid && bus.out_ready;
         if (xfer) got[rcvd] = bus.sum;
         @(posedge clk); #1;
         if (acc) sent++;
         if (xfer) rcvd++;
      end
      bus.in_valid = 0;
      n_checks++; if (rcvd !== 4) begin n_fail++; $display("FAIL bp_count got=%0d exp=4", rcvd); end
      n_checks++; if (got[0] !== 8'h10 || got[1] !== 8'h21 || got[2] !== 8'h32 || got[3] !== 8'h43)
         begin n_fail++; $display("FAIL bp_order got=%h %h %h %h exp=10 21 32 43", got[0], got[1], got[2], got[3]); end
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_dup got out_valid=%b exp=0", bus.out_valid); end
   endtask

   task automatic test_stats();
      bus.a = 8'h2B; bus.b = 8'h31; bus.cin = 1; bus.mode = MODE_LOA;
      bus.out_ready = 1; bus.in_valid = 1;
      repeat (65540) @(posedge clk);
      #1; bus.in_valid = 0;
      repeat (4) @(posedge clk);
      #1;
      n_checks++; if (bus.err_count !== 16'hFFFF) begin n_fail++; $display("FAIL stats_sat got=%h exp=ffff", bus.err_count); end
      run_vec(8'h2B, 8'h31, 1'b1, MODE_LOA);
      n_checks++; if (bus.err_count !== 16'hFFFF) begin n_fail++; $display("FAIL stats_sat_hold got=%h exp=ffff", bus.err_count); end
      bus.out_ready = 0; bus.in_valid = 1;
      @(posedge clk); #1;
      bus.in_valid = 0;
      @(posedge clk); #1;
      bus.clr_stats = 1; bus.out_ready = 1;
      @(posedge clk); #1;
      bus.clr_stats = 0;
      n_checks++; if (bus.err_count !== 16'h0) begin n_fail++; $display("FAIL stats_clr got=%h exp=0", bus.err_count); end
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stats_clr_xfer got out_valid=%b exp=0", bus.out_valid); end
   endtask

   task automatic test_reset_inflight();
      logic seen;
      seen = 0;
      bus.a = 8'h12; bus.b = 8'h34; bus.cin = 0; bus.mode = MODE_EXACT;
      bus.out_ready = 0; bus.in_valid = 1;
      repeat (2) begin @(posedge clk); #1; end
      bus.in_valid = 0;
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre got out_valid=%b exp=1", bus.out_valid); end
      rst = 1;
      #1;
      n_checks++; if (bus.out_valid !== 1'b0 || bus.sum !== 8'h00) begin n_fail++; $display("FAIL rst_async got=%b/%h exp=0/00", bus.out_valid, bus.sum); end
      @(posedge clk); #1;
      rst = 0; bus.out_ready = 1;
      repeat (5) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen = 1;
      end
      n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_flush got out_valid seen=%b exp=0", seen); end
   endtask

   initial begin
      test_reset();
      test_exact();
      test_loa();
      test_trunc();
      test_wrap();
      test_back_to_back();
      test_stats();
      test_reset_inflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
